symbol_serializer: RTL and testbench

Parametrised word-to-symbol serializer for the transmit path: it accepts a NUM_SYM×SYM_W-bit word over a valid/ready handshake and emits it one SYM_W-bit symbol per handshake, in MSB-first or LSB-first order. It replaces the fixed 24-bit/4-bit, enable-loaded nibble buffer. It adds back-pressure, a one-word pending slot for gap-free back-to-back words, and framing flags. It sits between the word-level encoder and the symbol modulator.

---
 rtl/ser_pkg.sv | 17 +
 rtl/symbol_serializer.sv | 112 +++++++++++
 tb/tb_symbol_serializer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared defaults and helpers for the transmit-path word-to-symbol serializer.
package ser_pkg;

   localparam int unsigned SYM_W_DEF   = 4;
   localparam int unsigned NUM_SYM_DEF = 6;

   localparam bit MODE_MSB_FIRST = 1'b1;
   localparam bit MODE_LSB_FIRST = 1'b0;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/symbol_serializer.sv
// Word-to-symbol serializer with a current/pending word slot pair and framing flags.
module symbol_serializer
   import ser_pkg::*;
#(
   parameter int unsigned SYM_W     = SYM_W_DEF,
   parameter int unsigned NUM_SYM   = NUM_SYM_DEF,
   parameter bit          MSB_FIRST = MODE_MSB_FIRST
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [SYM_W*NUM_SYM-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [SYM_W-1:0]         out_sym,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_first,
   output logic                     out_last
);

   localparam int unsigned WORD_W = SYM_W * NUM_SYM;
   localparam int unsigned IDX_W  = idx_width(NUM_SYM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYM - 1);

   logic [WORD_W-1:0] cur_q, cur_d;
   logic [WORD_W-1:0] pend_q, pend_d;
   logic              cur_full_q, cur_full_d;
   logic              pend_full_q, pend_full_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   logic              in_fire;
   logic              out_fire;
   logic              done;

   logic [SYM_W-1:0]  sym_arr [NUM_SYM];
   logic [IDX_W-1:0]  sel;

   assign in_ready  = ~pend_full_q;
   assign out_valid = cur_full_q;
   assign out_first = cur_full_q && (idx_q == '0);
   assign out_last  = cur_full_q && (idx_q == LAST_IDX);

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign done     = out_fire && (idx_q == LAST_IDX);

   // Symbol index 0 is the least-significant slice of the word.
   always_comb begin
      for (int unsigned i = 0; i < NUM_SYM; i++) begin
         sym_arr[i] = cur_q[i*SYM_W +: SYM_W];
      end
   end

   assign sel     = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
   assign out_sym = sym_arr[sel];

   always_comb begin
      cur_d       = cur_q;
      pend_d      = pend_q;
      cur_full_d  = cur_full_q;
      pend_full_d = pend_full_q;
      idx_d       = idx_q;

      if (out_fire && !done) begin
         idx_d = idx_q + IDX_W'(1);
      end

      // Word completion: refill from the pending slot first, then from the input.
      if (done) begin
         idx_d = '0;
         if (pend_full_q) begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
         end else if (in_fire) begin
            cur_d = in_data;
         end else begin
            cur_full_d = 1'b0;
         end
      end

      // in_fire with done is already handled above (pend_full blocks in_ready).
      if (in_fire && !done) begin
         if (!cur_full_q) begin
            cur_d      = in_data;
            cur_full_d = 1'b1;
            idx_d      = '0;
         end else begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_full_q  <= 1'b0;
         pend_full_q <= 1'b0;
         idx_q       <= '0;
      end else begin
         cur_full_q  <= cur_full_d;
         pend_full_q <= pend_full_d;
         idx_q       <= idx_d;
      end
   end

   // Payload registers are qualified by the flags, so they carry no reset.
   always_ff @(posedge clk) begin
      cur_q  <= cur_d;
      pend_q <= pend_d;
   end

endmodule

// File: tb/tb_symbol_serializer.sv
// Bench for symbol_serializer: MSB-first and LSB-first instances against a symbol-queue model.
module tb_symbol_serializer;

   localparam int unsigned SW = 4;
   localparam int unsigned NS = 6;
   localparam int unsigned WW = SW * NS;

   logic          clk = 1'b0;
   logic          reset;
   logic [WW-1:0] in_data;
   logic          in_valid;
   logic          out_ready;

   logic          in_ready_m, out_valid_m, out_first_m, out_last_m;
   logic [SW-1:0] out_sym_m;
   logic          in_ready_l, out_valid_l, out_first_l, out_last_l;
   logic [SW-1:0] out_sym_l;

   logic [SW-1:0] q_m[$];
   logic [SW-1:0] q_l[$];

   int  checks = 0;
   int  errors = 0;
   bit  fired;

   always #5 clk = ~clk;

   symbol_serializer #(.SYM_W(SW), .NUM_SYM(NS), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_m), .out_sym(out_sym_m), .out_valid(out_valid_m),
      .out_ready(out_ready), .out_first(out_first_m), .out_last(out_last_m)
   );

   symbol_serializer #(.SYM_W(SW), .NUM_SYM(NS), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_l), .out_sym(out_sym_l), .out_valid(out_valid_l),
      .out_ready(out_ready), .out_first(out_first_l), .out_last(out_last_l)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [WW-1:0] w);
      for (int i = 0; i < int'(NS); i++) begin
         q_m.push_back(w[(int'(NS)-1-i)*int'(SW) +: SW]);
         q_l.push_back(w[i*int'(SW) +: SW]);
      end
   endtask

   // Each queued word is NS symbols; the front symbol is what must be on the wire.
   task automatic check_outputs(output bit exp_ready, output bit exp_valid);
      int words;
      int pos;
      words     = (q_m.size() + int'(NS) - 1) / int'(NS);
      exp_ready = (words < 2);
      exp_valid = (q_m.size() > 0);
      pos       = q_m.size() % int'(NS);
      chk("in_ready_msb",  32'(in_ready_m),  32'(exp_ready));
      chk("in_ready_lsb",  32'(in_ready_l),  32'(exp_ready));
      chk("out_valid_msb", 32'(out_valid_m), 32'(exp_valid));
      chk("out_valid_lsb", 32'(out_valid_l), 32'(exp_valid));
      if (exp_valid) begin
         chk("out_sym_msb",   32'(out_sym_m),   32'(q_m[0]));
         chk("out_sym_lsb",   32'(out_sym_l),   32'(q_l[0]));
         chk("out_first_msb", 32'(out_first_m), 32'(pos == 0));
         chk("out_first_lsb", 32'(out_first_l), 32'(pos == 0));
         chk("out_last_msb",  32'(out_last_m),  32'(pos == 1));
         chk("out_last_lsb",  32'(out_last_l),  32'(pos == 1));
      end else begin
         chk("out_first_idle", 32'({out_first_m, out_first_l}), 32'(0));
         chk("out_last_idle",  32'({out_last_m, out_last_l}),   32'(0));
      end
   endtask

   task automatic cycle();
      bit exp_ready, exp_valid, inf, outf;
      @(negedge clk);
      check_outputs(exp_ready, exp_valid);
      inf  = in_valid && exp_ready;
      outf = exp_valid && out_ready;
      @(posedge clk);
      if (outf) begin
         void'(q_m.pop_front());
         void'(q_l.pop_front());
      end
      if (inf) push_word(in_data);
      fired = inf;
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_out_valid"}, 32'({out_valid_m, out_valid_l}), 32'(0));
      chk({tag, "_in_ready"},  32'({in_ready_m, in_ready_l}),   32'(3));
      chk({tag, "_first"},     32'({out_first_m, out_first_l}), 32'(0));
      chk({tag, "_last"},      32'({out_last_m, out_last_l}),   32'(0));
   endtask

   logic [WW-1:0] three_words [3];
   int            sent;
   int            budget;

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #12;
      check_reset_state("reset");
      @(posedge clk);
      #1 reset = 1'b1;

      // Single word streamed with out_ready held high.
      in_data  = 24'hABCDEF;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (8) cycle();

      // Back-to-back words with the second captured in the pending slot.
      in_data  = 24'h123456;
      in_valid = 1'b1;
      cycle();
      in_data  = 24'h789ABC;
      cycle();
      chk("b2b_second_accept", 32'(fired), 32'(1));
      in_valid = 1'b0;
      repeat (14) cycle();

      // Back-pressure while symbol C is presented.
      in_data  = 24'hABCDEF;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (2) cycle();
      out_ready = 1'b0;
      repeat (3) cycle();
      out_ready = 1'b1;
      repeat (6) cycle();

      // Three words offered continuously; the third waits for the first to finish.
      three_words[0] = 24'h13579B;
      three_words[1] = 24'h2468AC;
      three_words[2] = 24'hFEDCBA;
      sent   = 0;
      budget = 0;
      in_valid = 1'b1;
      while (sent < 3 && budget < 40) begin
         in_data = three_words[sent];
         cycle();
         if (fired) sent++;
         budget++;
      end
      chk("pend_all_accepted", 32'(sent), 32'(3));
      chk("pend_third_wait", 32'(budget), 32'(NS + 2));
      in_valid = 1'b0;
      repeat (20) cycle();

      // Randomized traffic and back-pressure.
      repeat (1500) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = WW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (20) cycle();

      // Reset asserted mid-word after three symbols.
      in_data  = 24'hABCDEF;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
      reset = 1'b0;
      #1;
      check_reset_state("midword_reset");
      q_m.delete();
      q_l.delete();
      @(posedge clk);
      #1 reset = 1'b1;
      in_data  = 24'h000001;
      in_valid = 1'b1;
      cycle();
      chk("post_reset_accept", 32'(fired), 32'(1));
      in_valid = 1'b0;
      repeat (8) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
